// File: rtl/delay_align_reader.sv
// delay_align_reader
//    Read-side companion to the fixed pipeline delay stages. Buffers a signed
//    sample stream from an upstream writer and holds it back until PRIME_LEVEL
//    samples have accumulated. After that it releases samples to a consumer
//    under a valid/ready handshake. Once the buffer drains, the stream must
//    re-prime before any more output is released.
//
//    Ports
//       clk        clock, all state changes on the rising edge
//       reset      synchronous active-low reset (0 = reset)
//       in_data    signed sample from the writer
//       in_valid   in_data is valid this cycle
//       in_ready   buffer can accept a write this cycle
//       out_data   head sample (first-word-fall-through), held while idle
//       out_valid  out_data is valid to the consumer
//       out_ready  consumer accepts out_data this cycle
//       level      current occupancy, 0..DEPTH
//       overflow   sticky flag: a write was offered while in_ready was low
module delay_align_reader #(
   parameter int DATA_W      = 25,
   parameter int DEPTH       = 8,
   parameter int PTR_W       = 3,
   parameter int PRIME_LEVEL = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PTR_W:0]    level,
   output logic              overflow
);

   typedef enum logic {
      PRIME  = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam logic [PTR_W:0]   FULL_LVL  = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   PRIME_LVL = PRIME_LEVEL[PTR_W:0];
   localparam logic [PTR_W:0]   LVL_ONE   = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W:0]    level_q, level_d;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] outHold_q;
   state_t            state_q, state_d;
   logic              wrEn, rdEn;

   // Handshake decode. in_ready looks only at occupancy, so a full buffer
   // refuses a write even when the consumer reads in the same cycle.
   // out_data follows the head entry while valid. Otherwise it holds the
   // last value it showed, which is 0 straight after reset.
   always_comb begin
      in_ready  = (level_q != FULL_LVL);
      out_valid = (state_q == STREAM) && (level_q != '0);
      out_data  = out_valid ? mem_q[rdPtr_q] : outHold_q;
      level     = level_q;
      overflow  = overflow_q;
      wrEn      = in_valid && in_ready;
      rdEn      = out_valid && out_ready;
   end

   // Next-state logic for pointers, occupancy, the sticky overflow flag and
   // the prime/stream FSM. A write that lands together with the read of the
   // last entry keeps level at 1, so the stream does not need to re-prime.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      state_d    = state_q;

      if (wrEn) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (rdEn) begin
         rdPtr_d = rdPtr_q + PTR_ONE;
      end

      case ({wrEn, rdEn})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      if (in_valid && !in_ready) begin
         overflow_d = 1'b1;
      end

      case (state_q)
         PRIME: begin
            if (level_d >= PRIME_LVL) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (level_d == '0) begin
               state_d = PRIME;
            end
         end
         default: state_d = PRIME;
      endcase
   end

   // Control registers. Reset throws away everything that was buffered by
   // clearing the pointers and the occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         outHold_q  <= '0;
         state_q    <= PRIME;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         outHold_q  <= out_data;
         state_q    <= state_d;
      end
   end

   // Sample storage. It has no reset because its contents are meaningless
   // until the occupancy says an entry is live.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem_q[wrPtr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_delay_align_reader.sv
// tb_delay_align_reader
//    Checks delay_align_reader against a queue-based reference model. Directed
//    scenarios cover priming latency, backpressure fill with overflow, reading
//    at full, signed extremes with pointer wrap, and reset during streaming.
//    A randomized phase then mixes traffic, stalls and occasional resets.
module tb_delay_align_reader;

   localparam int DATA_W      = 25;
   localparam int DEPTH       = 8;
   localparam int PTR_W       = 3;
   localparam int PRIME_LEVEL = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [PTR_W:0]    level;
   logic              overflow;

   int checks   = 0;
   int failures = 0;

   // Reference model state: the buffered samples in order, whether output
   // is currently released, the sticky overflow flag and the held out_data.
   logic [DATA_W-1:0] modelQ [$];
   bit                modelStream;
   bit                modelOvf;
   logic [DATA_W-1:0] modelHold;

   always #5 clk = ~clk;

   delay_align_reader #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .PTR_W       (PTR_W),
      .PRIME_LEVEL (PRIME_LEVEL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow)
   );

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Runs one clock cycle. First it checks the DUT outputs against the
   // model. Then it drives the inputs, lets the edge happen, and advances
   // the model by the rules of the block.
   task automatic applyStimulus(input logic rstN, input logic iv,
                                input logic [DATA_W-1:0] d, input logic ordy);
      bit                expValid, expReady, doWr, doRd;
      logic [DATA_W-1:0] expData;
      expValid = modelStream && (modelQ.size() != 0);
      expReady = (modelQ.size() != DEPTH);
      expData  = expValid ? modelQ[0] : modelHold;

      checkOutput("level",     32'(level),     32'(modelQ.size()));
      checkOutput("in_ready",  32'(in_ready),  32'(expReady));
      checkOutput("out_valid", 32'(out_valid), 32'(expValid));
      checkOutput("out_data",  32'(out_data),  32'(expData));
      checkOutput("overflow",  32'(overflow),  32'(modelOvf));

      reset     = rstN;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(posedge clk);

      if (!rstN) begin
         modelQ.delete();
         modelStream = 1'b0;
         modelOvf    = 1'b0;
         modelHold   = '0;
      end else begin
         doWr = iv && expReady;
         doRd = expValid && ordy;
         if (iv && !expReady) modelOvf = 1'b1;
         modelHold = expData;
         if (doRd) void'(modelQ.pop_front());
         if (doWr) modelQ.push_back(d);
         if (!modelStream && modelQ.size() >= PRIME_LEVEL) modelStream = 1'b1;
         else if (modelStream && modelQ.size() == 0) modelStream = 1'b0;
      end
      #1;
   endtask

   initial begin
      logic [DATA_W-1:0] negMax;
      logic [DATA_W-1:0] posMax;
      int                readyBias;
      negMax = 25'h1000000;
      posMax = 25'h0FFFFFF;

      // Hold reset for two cycles, then check the idle state against fixed values.
      reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      modelQ.delete(); modelStream = 1'b0; modelOvf = 1'b0; modelHold = '0;
      checkOutput("rst_level",     32'(level),     32'd0);
      checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data",  32'(out_data),  32'd0);
      checkOutput("rst_overflow",  32'(overflow),  32'd0);

      // Prime latency: 100 then -5, after which the stream drains back to PRIME.
      applyStimulus(1'b1, 1'b1, DATA_W'(100), 1'b1);
      applyStimulus(1'b1, 1'b1, DATA_W'(-5), 1'b1);
      checkOutput("prime_valid_rise", 32'(out_valid), 32'd1);
      checkOutput("prime_first_data", 32'(out_data), 32'(DATA_W'(100)));
      repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1);
      checkOutput("prime_reprime", 32'(out_valid), 32'd0);

      // Backpressure fill, then an overflow attempt with 9.
      for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b1, DATA_W'(i), 1'b0);
      applyStimulus(1'b1, 1'b1, DATA_W'(9), 1'b0);
      checkOutput("fill_overflow", 32'(overflow), 32'd1);
      // Reading at full: the write offered in the same cycle is refused.
      applyStimulus(1'b1, 1'b1, DATA_W'(77), 1'b1);
      checkOutput("full_read_level", 32'(level), 32'(DEPTH - 1));
      applyStimulus(1'b1, 1'b1, DATA_W'(78), 1'b0);
      checkOutput("after_full_level", 32'(level), 32'(DEPTH));
      repeat (DEPTH + 2) applyStimulus(1'b1, 1'b0, '0, 1'b1);

      // Signed extremes with continuous draining; the pointers wrap.
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? negMax : posMax, 1'b1);
      repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1);

      // Reset while streaming at level 5.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, DATA_W'(40 + i), 1'b0);
      checkOutput("mid_level5", 32'(level), 32'd5);
      applyStimulus(1'b0, 1'b1, DATA_W'(99), 1'b1);
      checkOutput("mid_rst_level", 32'(level), 32'd0);
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);

      // Randomized traffic, with the consumer's stall bias changing per burst.
      readyBias = 50;
      for (int i = 0; i < 800; i++) begin
         if (i % 50 == 0) readyBias = $urandom_range(10, 90);
         applyStimulus(($urandom_range(0, 99) != 0),
                       ($urandom_range(0, 99) < 65),
                       DATA_W'($urandom),
                       ($urandom_range(0, 99) < readyBias));
      end
      applyStimulus(1'b1, 1'b0, '0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/delay_align_reader.md
Name: delay_align_reader

Overview:
- Read-side companion to the fixed pipeline delay stages. It buffers a 25-bit signed sample stream written by an upstream stage with a valid strobe.
- It withholds output until a programmable number of samples has accumulated (delay alignment). It then releases samples to a downstream consumer under a valid/ready handshake.
- It sits between a filter/datapath stage and a consumer that may stall, so that stall behaviour and alignment delay are both explicit.

Parameters:
- DATA_W, 25, sample width (signed, two's complement)
- DEPTH, 8, buffer entries (power of two, >= 2)
- PTR_W, 3, log2(DEPTH)
- PRIME_LEVEL, 2, samples required before output is released (1..DEPTH)

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- in_data  in  DATA_W  signed sample from writer
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  buffer can accept a write this cycle
- out_data  out  DATA_W  signed sample at buffer head
- out_valid  out  1  out_data valid to consumer
- out_ready  in  1  consumer accepts out_data this cycle
- level  out  PTR_W+1  current occupancy 0..DEPTH
- overflow  out  1  sticky: write attempted while in_ready=0

Behaviour:
- Reset (reset=0 at clk edge):
  - write pointer, read pointer and level return to 0; overflow returns to 0; state returns to PRIME.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, level=0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all buffered samples; no partial handshake survives.
- Write: occurs at the edge when in_valid=1 and in_ready=1. in_ready = (level != DEPTH), combinational from level only. in_ready never depends on out_ready, so there is no full-bypass.
- Read: occurs at the edge when out_valid=1 and out_ready=1.
  - out_data is first-word-fall-through: it shows the head entry whenever out_valid=1.
  - out_data is held at the last driven value (0 after reset) when out_valid=0.
- Pointers wrap modulo DEPTH. Level update per edge:
  - +1 on write only
  - -1 on read only
  - unchanged on simultaneous write and read
- State machine (2 states):
  - PRIME:
    - out_valid=0.
    - Go to STREAM at the edge where level_next >= PRIME_LEVEL.
    - out_valid rises in the cycle right after the PRIME_LEVEL-th write. With PRIME_LEVEL=2, the first sample appears 2 write-cycles after it was written.
  - STREAM:
    - out_valid = (level != 0).
    - Return to PRIME at the edge where level_next == 0, i.e. the last sample is read and there is no simultaneous write. The stream must then re-prime.
    - If a write coincides with the read of the last entry, remain in STREAM.
- Boundary conditions:
  - Full (level=DEPTH) with out_ready=1: read occurs; in_ready=0 that cycle, so no write. The next cycle in_ready=1.
  - Empty in STREAM with in_valid=1: cannot occur, because reaching empty forces PRIME.
  - Empty in PRIME: write only.
  - Overflow: in_valid=1 while in_ready=0 sets overflow at that edge. It stays set until reset. The offered sample is dropped and buffered data is untouched.
- Data integrity:
  - Samples leave in write order, bit-exact, with sign preserved.
  - No arithmetic is performed on the data.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release -> level=0, in_ready=1, out_valid=0, out_data=0, overflow=0.
- Prime latency: write 100 then -5 on consecutive cycles with out_ready=1 -> out_valid rises the cycle after the -5 write. Outputs are 100 then -5 on successive cycles. The block then returns to PRIME (out_valid=0).
- Backpressure fill: out_ready=0, write 1..8 -> level=8, in_ready=0. Write 9 attempted -> overflow=1, 9 dropped. Raise out_ready -> outputs 1..8 in order.
- Concurrent read/write at full: level=8, in_valid=1 and out_ready=1 for one cycle -> read only, level=7. The next cycle's write is accepted.
- Negative extremes and wrap: stream 20 samples alternating -16777216 and 16777215 with out_ready=1 continuously (pointers wrap twice) -> identical sequence out, no drops. Level stays at 1 or 2.
- Mid-stream reset: level=5 in STREAM, assert reset=0 for 1 cycle -> next cycle level=0, out_valid=0, state PRIME, overflow=0.
